// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator:
// FSM states, exception cause codes and redirect-select encoding.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_ADDR = 2'd2;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_EXC  = 3'd1,
    SEL_ERET = 3'd2,
    SEL_JMP  = 3'd3,
    SEL_BR   = 3'd4
  } redir_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control/hazard side to PC generator bundle: redirect requests, fetch
// handshake and the PC/exception status returned to the pipeline.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              fetch_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_target;
  logic              exc_req;
  logic [ADDR_W-1:0] exc_pc;
  logic              eret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              fetch_valid;
  logic [ADDR_W-1:0] epc;
  logic [1:0]        exc_cause;
  logic              in_exc;
  logic              halted;

  modport master (
    output stall, fetch_ready, br_taken, br_target, jmp_valid, jmp_target,
           exc_req, exc_pc, eret,
    input  pc, pc_next_seq, fetch_valid, epc, exc_cause, in_exc, halted
  );

  modport slave (
    input  stall, fetch_ready, br_taken, br_target, jmp_valid, jmp_target,
           exc_req, exc_pc, eret,
    output pc, pc_next_seq, fetch_valid, epc, exc_cause, in_exc, halted
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: exception > eret > jump > branch,
// plus alignment check on the selected eret/jump/branch target.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic              exc_req,
  input  logic              eret,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] epc,
  output redir_sel_e        sel,
  output logic [ADDR_W-1:0] target,
  output logic              addr_err
);

  // Mask form keeps ALIGN_BITS=0 legal (no alignment requirement).
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  always_comb begin
    sel    = SEL_NONE;
    target = '0;
    if (exc_req) begin
      sel = SEL_EXC;
    end else if (eret) begin
      sel    = SEL_ERET;
      target = epc;
    end else if (jmp_valid) begin
      sel    = SEL_JMP;
      target = jmp_target;
    end else if (br_taken) begin
      sel    = SEL_BR;
      target = br_target;
    end
    addr_err = (sel != SEL_NONE) && (sel != SEL_EXC) && (|(target & ALIGN_MASK));
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, fetch handshake, prioritised
// redirects, EPC/cause capture and double-fault halt.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       ALIGN_BITS   = 2,
  parameter int unsigned       BOOT_CYCLES  = 2
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  pc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              in_exc_q, in_exc_d;

  redir_sel_e        sel;
  logic [ADDR_W-1:0] target;
  logic              addr_err;
  logic              exc_event;
  logic              boot_done;
  logic              fetch_valid;
  logic              halted;
  logic              seq_adv;
  logic [ADDR_W-1:0] pc_next_seq;

  pc_redirect_arb #(
    .ADDR_W     (ADDR_W),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_arb (
    .exc_req    (bus.exc_req),
    .eret       (bus.eret),
    .jmp_valid  (bus.jmp_valid),
    .jmp_target (bus.jmp_target),
    .br_taken   (bus.br_taken),
    .br_target  (bus.br_target),
    .epc        (epc_q),
    .sel        (sel),
    .target     (target),
    .addr_err   (addr_err)
  );

  assign exc_event   = (sel == SEL_EXC) || addr_err;
  assign boot_done   = (boot_cnt_q == CNT_W'(BOOT_CYCLES - 1));
  assign pc_next_seq = pc_q + ADDR_W'(STEP);
  assign seq_adv     = fetch_valid && bus.fetch_ready && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      cause_q    <= CAUSE_NONE;
      in_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      in_exc_q   <= in_exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (boot_done) state_d = RUN;
      RUN:     if (exc_event && in_exc_q) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == RUN);
    halted      = (state_q == HALT);
  end

  // Datapath registers; a fault while in_exc is set only moves the FSM to HALT.
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    in_exc_d   = in_exc_q;
    case (state_q)
      BOOT: begin
        if (!boot_done) boot_cnt_d = boot_cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (exc_event) begin
          if (!in_exc_q) begin
            pc_d     = EXC_VECTOR;
            in_exc_d = 1'b1;
            epc_d    = addr_err ? target : bus.exc_pc;
            cause_d  = addr_err ? CAUSE_ADDR : CAUSE_EXT;
          end
        end else begin
          case (sel)
            SEL_ERET: begin
              pc_d     = target;
              in_exc_d = 1'b0;
            end
            SEL_JMP, SEL_BR: pc_d = target;
            default: if (seq_adv) pc_d = pc_next_seq;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = pc_next_seq;
  assign bus.fetch_valid = fetch_valid;
  assign bus.epc         = epc_q;
  assign bus.exc_cause   = cause_q;
  assign bus.in_exc      = in_exc_q;
  assign bus.halted      = halted;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the MIPS core; successor to the fixed single-cycle PC.
- Adds configurable reset/exception vectors, a boot delay, a valid/ready fetch handshake and stall.
- Adds prioritised redirects: exception, eret, jump, branch.
- Adds EPC/cause capture, misaligned-target trapping and a double-fault halt.
- Sits between the control/hazard logic and the instruction-memory request port.

Parameters:
- ADDR_W, 32, PC width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_VECTOR, 32'h0000_0000, PC value held from reset until the first advance.
- EXC_VECTOR, 32'h0000_0080, exception handler entry address.
- STEP, 4, sequential increment.
- ALIGN_BITS, 2, low target bits that must be zero.
- BOOT_CYCLES, 2, cycles after reset release with fetch disabled; legal range >= 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  blocks sequential advance only.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- br_taken  in  1  branch redirect request.
- br_target  in  ADDR_W  branch target.
- jmp_valid  in  1  jump redirect request.
- jmp_target  in  ADDR_W  jump target.
- exc_req  in  1  external/decode exception request.
- exc_pc  in  ADDR_W  PC of the faulting instruction.
- eret  in  1  return from exception.
- pc  out  ADDR_W  current fetch address.
- pc_next_seq  out  ADDR_W  pc + STEP, combinational.
- fetch_valid  out  1  pc is a valid fetch request.
- epc  out  ADDR_W  saved exception PC.
- exc_cause  out  2  cause code: 0 none, 1 external, 2 address error.
- in_exc  out  1  handler active.
- halted  out  1  double fault occurred.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR, fetch_valid=0, epc=0, exc_cause=0, in_exc=0, halted=0.
  - state=BOOT, boot counter=0.
  - Asserting reset mid-operation aborts everything immediately.
- State BOOT:
  - All request inputs are ignored; pc is held.
  - Counter increments each cycle; after BOOT_CYCLES cycles, go to RUN.
  - fetch_valid=1 from the first RUN cycle.
- State RUN: one action per cycle, highest priority first:
  1. exc_req: cause=1, epc<=exc_pc.
  2. eret: target=epc, in_exc<=0.
  3. jmp_valid: target=jmp_target.
  4. br_taken: target=br_target.
  5. Sequential: only when fetch_valid & fetch_ready & !stall; pc<=pc+STEP, which wraps to 0 past 2^ADDR_W-1.
  6. Otherwise pc holds; pc is stable while fetch_valid & !fetch_ready.
- Redirect timing:
  - Redirects (1-4) apply next cycle regardless of stall or fetch_ready; an unaccepted fetch is abandoned.
  - Redirect latency is 1 cycle: request in cycle N, new pc visible in cycle N+1.
- Misaligned target: an eret/jmp/br target whose [ALIGN_BITS-1:0] != 0 is trapped as an address error.
  - cause=2, epc<=bad target, pc<=EXC_VECTOR.
- Exception entry (cause 1 or 2), when in_exc=0:
  - pc<=EXC_VECTOR, in_exc<=1, and epc/exc_cause are written.
- Double fault: any exception while in_exc=1.
  - state<=HALT, halted<=1, fetch_valid<=0.
  - epc and cause are not overwritten.
- State HALT:
  - Absorbing; all inputs ignored; exit only via reset.
  - pc holds its last value.
- eret while in_exc=0 is a legal return to epc; exc_cause is left unchanged.
- Simultaneous requests resolve strictly by the priority above; lower-priority requests are dropped, not queued.

Decomposition:
- Package pc_gen_pkg:
  - state encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - cause constants: CAUSE_NONE, CAUSE_EXT, CAUSE_ADDR.
  - redirect-select encoding.
- Sub-module pc_redirect_arb: combinational priority select and alignment check.
  - Inputs: exc_req, eret, jmp/br requests and targets, epc.
  - Outputs: sel, target, addr_err.
- pc_gen holds the FSM, boot counter, pc, epc, cause and in_exc registers.

Test Plan:
- Boot: release rst_n with BOOT_CYCLES=2 -> fetch_valid=0 for 2 cycles, then 1 with pc=0x0; with fetch_ready=1, pc reads 0x4 and 0x8 on the next 2 cycles.
- Handshake/stall: fetch_ready=0 for 3 cycles, then stall=1 for 2 cycles, from pc=0x10 -> pc holds 0x10 throughout; advances to 0x14 on the first cycle with ready=1 and stall=0.
- Priority: exc_req (exc_pc=0x20), jmp_valid (0x400) and br_taken (0x800) in the same cycle -> pc=0x80, epc=0x20, cause=1, in_exc=1; then eret -> pc=0x20, in_exc=0.
- Misaligned: br_taken with br_target=0x102 -> pc=0x80, epc=0x102, cause=2; a jmp to 0x104 during stall=1 -> pc=0x104 the next cycle.
- Double fault and wrap:
  - Double fault: exc_req while in_exc=1 -> halted=1, fetch_valid=0, epc unchanged; all inputs ignored until rst_n pulse restores pc=RESET_VECTOR.
  - Wrap: jmp to 0xFFFF_FFFC, then one accepted fetch -> pc=0x0.
